// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues word fetches over a req/ack handshake and
// queues returned words with their PC+4 for the IF/ID register; redirect flushes.
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_plus4
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

    state_t          r_state;
    logic            r_req;
    logic [31:0]     r_addr;
    logic [31:0]     r_pc;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [31:0]     r_instr [DEPTH];
    logic [31:0]     r_pc4   [DEPTH];

    logic            w_ack;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic [CW-1:0]   w_count_nxt;
    logic [31:0]     w_target;
    logic [31:0]     w_addr_inc;

    assign w_ack       = imem_ack & r_req;
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid & ~stall & ~redirect;
    assign w_push      = (r_state == FETCH) & w_ack & ~redirect;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_target    = redirect_pc & 32'hFFFF_FFFC;
    assign w_addr_inc  = r_addr + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_pc4[i]   <= '0;
            end
        end else if (redirect) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_instr[r_wptr] <= imem_rdata;
                r_pc4[r_wptr]   <= w_addr_inc;
                r_wptr          <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // A new request is only raised when a slot is guaranteed free at issue time,
    // so an ack can never find the FIFO full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
            r_pc    <= RESET_PC;
        end else begin
            case (r_state)
                IDLE: begin
                    if (redirect) begin
                        r_pc <= w_target;
                    end else if (r_count < FULL) begin
                        r_state <= FETCH;
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        r_pc <= w_target;
                        if (w_ack) begin
                            r_state <= IDLE;
                            r_req   <= 1'b0;
                        end else begin
                            r_state <= DROP;
                        end
                    end else if (w_ack) begin
                        r_pc <= w_addr_inc;
                        if (w_count_nxt < FULL) begin
                            r_addr <= w_addr_inc;
                        end else begin
                            r_state <= IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (redirect) begin
                        r_pc <= w_target;
                    end
                    if (w_ack) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req     = r_req;
    assign imem_addr    = r_addr;
    assign out_valid    = w_valid;
    assign out_instr    = r_instr[r_rptr];
    assign out_pc_plus4 = r_pc4[r_rptr];

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer with a memory model and a scoreboard
// queue of expected {instr, pc+4} entries popped as the head is consumed.
module tb_instr_prefetch_buffer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus4;

    instr_prefetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc_plus4 (out_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    ent_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          pops  = 0;
    logic [31:0] exp_addr;
    logic [31:0] drop_addr;
    logic        dropping;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, score the cycle just before the edge, advance.
    task automatic step(input logic a, input logic s, input logic r, input logic [31:0] rpc);
        ent_t e;
        imem_ack    = a;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_rdata  = mem_word(imem_addr);
        #2;
        chk("valid", 32'(out_valid), 32'(sb.size() != 0));
        if (a && imem_req) begin
            chk("ack_addr", imem_addr, dropping ? drop_addr : exp_addr);
            if (dropping) begin
                dropping = 1'b0;
            end else if (!r) begin
                sb.push_back({mem_word(exp_addr), exp_addr + 32'd4});
                exp_addr = exp_addr + 32'd4;
            end
        end
        if (out_valid && !s && !r) begin
            if (sb.size() == 0) begin
                chk("pop_empty", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("instr", out_instr, e.instr);
                chk("pc4", out_pc_plus4, e.pc4);
                pops++;
            end
        end
        if (r) begin
            if (!dropping && imem_req && !a) begin
                dropping  = 1'b1;
                drop_addr = exp_addr;
            end
            sb.delete();
            exp_addr = rpc & 32'hFFFF_FFFC;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_pc4", out_pc_plus4, 32'd0);
        sb.delete();
        dropping = 1'b0;
        exp_addr = RESET_PC;
        pops     = 0;
        reset    = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        #1;
        do_reset();

        // Streaming: ack every cycle, no stall.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
        chk("stream_pops", 32'(pops), 32'd8);
        chk("stream_addr", exp_addr, 32'd36);

        // Stall fills exactly DEPTH entries, then request drops.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_cnt", 32'(sb.size()), 32'd4);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
        chk("drain_addr", exp_addr, 32'd48);

        // Ack delayed three cycles: request and address held.
        do_reset();
        step(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, 32'd0);
            step(1'b0, 1'b0, 1'b0, '0);
        end
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            chk("wait2_addr", imem_addr, 32'd4);
            step(1'b0, 1'b0, 1'b0, '0);
        end
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("delay_pops", 32'(pops), 32'd2);

        // Redirect while a fetch awaits its ack.
        do_reset();
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        chk("drop_req", 32'(imem_req), 32'd1);
        chk("drop_addr", imem_addr, 32'd0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("drop_idle_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("tgt_req", 32'(imem_req), 32'd1);
        chk("tgt_addr", imem_addr, 32'h0000_0100);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("redir_pops", 32'(pops), 32'd1);

        // Redirect coincident with ack and pop on a nearly full queue.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);
        chk("pre_cnt", 32'(sb.size()), 32'd3);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0200);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("flush_tgt", imem_addr, 32'h0000_0200);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("flush_pops", 32'(pops), 32'd1);

        // Asynchronous reset while a fetch is outstanding; late ack ignored.
        do_reset();
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        reset = 1'b1;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        dropping = 1'b0;
        exp_addr = RESET_PC;
        pops     = 0;
        step(1'b1, 1'b0, 1'b0, '0);
        chk("post_req", 32'(imem_req), 32'd1);
        chk("post_addr", imem_addr, RESET_PC);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("post_pops", 32'(pops), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
